ret_stack: RTL and testbench

- Return-address stack that services the control unit's push/pop strobes: PC+1 saved on call, restored on return.
- Sits beside the PC mux in the datapath.
- Drives the value selected when s_pila=1.
- Top-of-stack is presented combinationally, so a pop instruction redirects the PC in the same cycle it executes.

---
 rtl/ret_stack_pkg.sv | 5 +
 rtl/ret_stack_mem.sv | 23 ++
 rtl/ret_stack.sv | 112 +++++++++++
 tb/tb_ret_stack.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ret_stack_pkg.sv
// Shared CPU constants used by the return-address stack.
package ret_stack_pkg;
  localparam int PC_WIDTH        = 10;
  localparam int RET_STACK_DEPTH = 16;
endpackage

// File: rtl/ret_stack_mem.sv
// Register array with one synchronous write port and one asynchronous read port.
module ret_stack_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ret_stack.sv
// Return-address stack: PC+1 saved on call, restored on return.
// Top-of-stack is combinational so a return redirects the PC in the same cycle.
module ret_stack
  import ret_stack_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = RET_STACK_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           d_in,
  output logic [WIDTH-1:0]           d_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    r_sp;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic [CW-1:0]    w_sp_m1;
  logic [AW-1:0]    w_top_idx;
  logic [WIDTH-1:0] w_rdata;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [CW-1:0]    w_sp_next;
  logic             w_set_ovf;
  logic             w_set_unf;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == CW'(DEPTH));
  assign w_sp_m1   = r_sp - CW'(1);
  // Only meaningful when not empty; d_out is forced to 0 otherwise.
  assign w_top_idx = w_sp_m1[AW-1:0];

  always_comb begin
    w_we      = 1'b0;
    w_waddr   = '0;
    w_sp_next = r_sp;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (w_full) begin
          w_set_ovf = 1'b1;
        end else begin
          w_we      = 1'b1;
          w_waddr   = r_sp[AW-1:0];
          w_sp_next = r_sp + CW'(1);
        end
      end
      2'b01: begin
        if (w_empty) w_set_unf = 1'b1;
        else         w_sp_next = w_sp_m1;
      end
      2'b11: begin
        // Replace top; on an empty stack this degrades to a plain push.
        w_we = 1'b1;
        if (w_empty) begin
          w_waddr   = '0;
          w_sp_next = CW'(1);
        end else begin
          w_waddr   = w_top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sp        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_sp <= w_sp_next;
      if (w_set_ovf) r_overflow  <= 1'b1;
      if (w_set_unf) r_underflow <= 1'b1;
    end
  end

  ret_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we & reset),
    .i_waddr (w_waddr),
    .i_wdata (d_in),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );

  assign d_out     = w_empty ? '0 : w_rdata;
  assign count     = r_sp;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_ret_stack.sv
// Directed bench for ret_stack: the driver queues the outputs expected in each
// cycle, and a negedge monitor pops and compares them.
module tb_ret_stack;

  localparam int W  = 10;
  localparam int EW = W + 5 + 4;

  logic         clk;
  logic         reset;
  logic         push;
  logic         pop;
  logic [W-1:0] d_in;
  logic [W-1:0] d_out;
  logic [4:0]   count;
  logic         empty;
  logic         full;
  logic         overflow;
  logic         underflow;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  ret_stack dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .d_in      (d_in),
    .d_out     (d_out),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] pk(input logic [W-1:0] d, input int c,
                                       input logic o, input logic u);
    return {d, 5'(c), (c == 0), (c == 16), o, u};
  endfunction

  // driver: apply inputs for one cycle and queue the outputs expected during it
  task automatic cyc(input logic rst_n, input logic ps, input logic pp,
                     input logic [W-1:0] din, input logic chk,
                     input logic [W-1:0] ed, input int ec,
                     input logic eo, input logic eu, input string nm);
    reset = rst_n;
    push  = ps;
    pop   = pp;
    d_in  = din;
    if (chk) begin
      exp_q.push_back(pk(ed, ec, eo, eu));
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
  endtask

  // direct state check at the current time
  task automatic check_state(input string nm, input logic [W-1:0] ed, input int ec,
                             input logic eo, input logic eu);
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    e = pk(ed, ec, eo, eu);
    a = {d_out, count, empty, full, overflow, underflow};
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got d_out=%h count=%0d empty=%b full=%b ovf=%b unf=%b, want d_out=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
               nm, a[18:9], a[8:4], a[3], a[2], a[1], a[0],
               e[18:9], e[8:4], e[3], e[2], e[1], e[0]);
    end
  endtask

  // bounded wait for the scoreboard to drain
  task automatic wait_drain(input int max_cycles);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    #1;
    n_tests++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d expected entries still queued after %0d cycles",
               exp_q.size(), max_cycles);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    string         nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {d_out, count, empty, full, overflow, underflow};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got d_out=%h count=%0d empty=%b full=%b ovf=%b unf=%b, want d_out=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
                 nm, a[18:9], a[8:4], a[3], a[2], a[1], a[0],
                 e[18:9], e[8:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    d_in  = '0;
    @(posedge clk);
    #1;

    // reset then idle
    cyc(0, 0, 0, 0, 1, 10'h000, 0, 0, 0, "reset_state");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 10'h000, 0, 0, 0, "idle_after_reset");
    check_state("reset_state_direct", 10'h000, 0, 0, 0);

    // three pushes, three pops
    cyc(1, 1, 0, 10'h005, 1, 10'h000, 0, 0, 0, "push1_pre");
    cyc(1, 1, 0, 10'h012, 1, 10'h005, 1, 0, 0, "push2_pre");
    cyc(1, 1, 0, 10'h3FF, 1, 10'h012, 2, 0, 0, "push3_pre");
    cyc(1, 0, 1, 0,       1, 10'h3FF, 3, 0, 0, "pop1_cycle");
    cyc(1, 0, 1, 0,       1, 10'h012, 2, 0, 0, "pop2_cycle");
    cyc(1, 0, 1, 0,       1, 10'h005, 1, 0, 0, "pop3_cycle");
    cyc(1, 0, 0, 0,       1, 10'h000, 0, 0, 0, "empty_after_pops");

    // fill, then overflow
    for (int i = 0; i < 16; i++)
      cyc(1, 1, 0, 10'(32'h100 + i), 1, (i == 0) ? 10'h000 : 10'(32'h0FF + i), i, 0, 0, "fill");
    cyc(1, 1, 0, 10'h2AA, 1, 10'h10F, 16, 0, 0, "push_when_full");
    cyc(1, 0, 0, 0,       1, 10'h10F, 16, 1, 0, "overflow_set");
    cyc(1, 0, 1, 0,       1, 10'h10F, 16, 1, 0, "pop_after_ovf");
    cyc(1, 0, 0, 0,       1, 10'h10E, 15, 1, 0, "overflow_sticky");
    cyc(0, 0, 0, 0,       1, 10'h10E, 15, 1, 0, "pre_reset_ovf");
    cyc(1, 0, 0, 0,       1, 10'h000, 0, 0, 0, "ovf_cleared_by_reset");

    // underflow
    cyc(1, 0, 1, 0,       1, 10'h000, 0, 0, 0, "pop_empty");
    cyc(1, 0, 0, 0,       1, 10'h000, 0, 0, 1, "underflow_set");
    cyc(1, 1, 0, 10'h0A0, 1, 10'h000, 0, 0, 1, "push_after_unf");
    cyc(1, 0, 0, 0,       1, 10'h0A0, 1, 0, 1, "underflow_sticky");
    cyc(0, 0, 0, 0,       1, 10'h0A0, 1, 0, 1, "pre_reset_unf");

    // replace top
    cyc(1, 0, 0, 0,       1, 10'h000, 0, 0, 0, "unf_cleared_by_reset");
    cyc(1, 1, 0, 10'h011, 1, 10'h000, 0, 0, 0, "push_011");
    cyc(1, 1, 1, 10'h022, 1, 10'h011, 1, 0, 0, "replace_pre");
    cyc(1, 0, 0, 0,       1, 10'h022, 1, 0, 0, "replace_result");
    cyc(1, 0, 1, 0,       1, 10'h022, 1, 0, 0, "pop_replaced");
    cyc(1, 1, 1, 10'h033, 1, 10'h000, 0, 0, 0, "replace_empty_pre");
    cyc(1, 0, 0, 0,       1, 10'h033, 1, 0, 0, "replace_empty_result");

    // replace while full
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    for (int i = 0; i < 16; i++)
      cyc(1, 1, 0, 10'(32'h200 + i), 1, (i == 0) ? 10'h000 : 10'(32'h1FF + i), i, 0, 0, "fill2");
    cyc(1, 1, 1, 10'h1EE, 1, 10'h20F, 16, 0, 0, "replace_full_pre");
    cyc(1, 0, 0, 0,       1, 10'h1EE, 16, 0, 0, "replace_full_no_ovf");

    // reset beats a concurrent push
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(1, 1, 0, 10'h055, 1, 10'h000, 0, 0, 0, "push_055");
    cyc(1, 1, 0, 10'h066, 1, 10'h055, 1, 0, 0, "push_066");
    cyc(0, 1, 0, 10'h077, 1, 10'h066, 2, 0, 0, "reset_with_push_pre");
    cyc(1, 0, 0, 0,       1, 10'h000, 0, 0, 0, "reset_beats_push");
    cyc(1, 0, 1, 0,       1, 10'h000, 0, 0, 0, "empty_after_reset_push");

    wait_drain(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    if (n_fail == 0) $display("[TB] PASS");
    else             $display("[TB] FAIL");
    $finish;
  end

endmodule
